fsm_sequencer: RTL and testbench

//  Initiator/checker for the start/stop -> good/bad handshake of the on-board demo FSM.
//  On a go request it pulses start, then checks that good stays high for exactly

---
 rtl/fsm_pkg.sv | 22 ++
 rtl/sat_counter.sv | 20 ++
 rtl/fsm_sequencer.sv | 140 ++++++++++++++
 tb/tb_fsm_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared types for the start/stop -> good/bad run sequencer.
// State encoding plus timeout-counter width helper.
package fsm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_G,
    RUN,
    STOP,
    PASS,
    FAIL
  } seq_state_t;

  localparam int TIMEOUT_DEF = 16;
  localparam int TMO_W = $clog2(TIMEOUT_DEF);

  function automatic int tmo_w(input int t);
    return (t > 2) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
// Used for the pass/fail run tallies.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/fsm_sequencer.sv
// Run initiator/checker for the demo target handshake.
// Pulses start, checks the good/bad phases, then stops the target.
module fsm_sequencer
  import fsm_pkg::*;
#(
  parameter int GOOD_CYCLES = 3,
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             good,
  input  logic             bad,
  output logic             start,
  output logic             stop,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam int TW = tmo_w(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [7:0] GC = 8'(GOOD_CYCLES);

  seq_state_t st;
  seq_state_t nxt;
  logic [TW-1:0] tmo;
  logic [7:0] gcnt;
  logic tmo_hit;
  logic gc_hit;

  assign tmo_hit = (tmo == TLAST);
  assign gc_hit = (gcnt == GC);
  assign busy = (st != IDLE);

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE: begin
        if (go) nxt = START;
      end
      START: nxt = WAIT_G;
      WAIT_G: begin
        if (bad) nxt = FAIL;
        else if (good) nxt = RUN;
        else if (tmo_hit) nxt = FAIL;
      end
      RUN: begin
        unique case (1'b1)
          (good && !bad): begin
            if (gc_hit) nxt = FAIL;
          end
          (!good && bad): begin
            nxt = gc_hit ? STOP : FAIL;
          end
          default: nxt = FAIL;
        endcase
      end
      STOP: begin
        if (good) nxt = FAIL;
        else if (!bad) nxt = PASS;
        else if (tmo_hit) nxt = FAIL;
      end
      PASS: nxt = IDLE;
      FAIL: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
    end else begin
      st <= nxt;
    end
  end

  // tmo only advances while parked in a wait state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo <= '0;
    end else if (nxt != st) begin
      tmo <= '0;
    end else if (st == WAIT_G || st == STOP) begin
      tmo <= tmo + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt <= '0;
    end else if (st == START) begin
      gcnt <= '0;
    end else if (st == WAIT_G && nxt == RUN) begin
      gcnt <= 8'd1;
    end else if (st == RUN && nxt == RUN) begin
      gcnt <= gcnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start <= 1'b0;
      stop  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
      fail  <= 1'b0;
    end else begin
      start <= (nxt == START);
      stop  <= (nxt == STOP);
      done  <= (nxt == PASS) || (nxt == FAIL);
      if (nxt == PASS) begin
        pass <= 1'b1;
        fail <= 1'b0;
      end else if (nxt == FAIL) begin
        pass <= 1'b0;
        fail <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (nxt == PASS),
    .q    (pass_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (nxt == FAIL),
    .q    (fail_cnt)
  );

endmodule

// File: tb/tb_fsm_sequencer.sv
// Directed bench: vector table on a directly driven DUT,
// plus a behavioural demo target for timing and saturation runs.
module tb_fsm_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // DUT A: good/bad driven straight from the bench
  logic rst_n, go, good, bad;
  logic a_start, a_stop, a_busy, a_done, a_pass, a_fail;
  logic [7:0] a_pc, a_fc;
  logic [21:0] outa;

  assign outa = {a_start, a_stop, a_busy, a_done,
                 a_pass, a_fail, a_pc, a_fc};

  fsm_sequencer #(
    .GOOD_CYCLES(3), .TIMEOUT(16), .CNT_W(8)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .go(go),
    .good(good), .bad(bad),
    .start(a_start), .stop(a_stop), .busy(a_busy),
    .done(a_done), .pass(a_pass), .fail(a_fail),
    .pass_cnt(a_pc), .fail_cnt(a_fc)
  );

  // DUT B: cross-wired to a compliant demo target, 2-bit tallies
  logic rst_b, go_b, good_b, bad_b;
  logic b_start, b_stop, b_busy, b_done, b_pass, b_fail;
  logic [1:0] b_pc, b_fc;
  logic [2:0] tst;

  fsm_sequencer #(
    .GOOD_CYCLES(3), .TIMEOUT(16), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_b), .go(go_b),
    .good(good_b), .bad(bad_b),
    .start(b_start), .stop(b_stop), .busy(b_busy),
    .done(b_done), .pass(b_pass), .fail(b_fail),
    .pass_cnt(b_pc), .fail_cnt(b_fc)
  );

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) tst <= 3'd0;
    else begin
      case (tst)
        3'd0: if (b_start) tst <= 3'd1;
        3'd1: tst <= 3'd2;
        3'd2: tst <= 3'd3;
        3'd3: tst <= 3'd4;
        3'd4: if (b_stop) tst <= 3'd0;
        default: tst <= 3'd0;
      endcase
    end
  end

  assign good_b = (tst >= 3'd1) && (tst <= 3'd3);
  assign bad_b  = (tst == 3'd4);

  typedef struct {
    logic        go;
    logic        good;
    logic        bad;
    logic [21:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic vgo, vg, vb,
    input logic st, sp, bz, dn, p, f,
    input int pc, fc
  );
    vec_t v;
    v.go = vgo;
    v.good = vg;
    v.bad = vb;
    v.exp = {st, sp, bz, dn, p, f, 8'(pc), 8'(fc)};
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    go = v.go;
    good = v.good;
    bad = v.bad;
    step();
    chk($sformatf("vec%0d", idx), {10'd0, outa}, {10'd0, v.exp});
  endtask

  int n, k, cyc, last;

  initial begin
    rst_n = 1'b0; rst_b = 1'b0;
    go = 1'b0; good = 1'b0; bad = 1'b0; go_b = 1'b0;

    //     go g b  st sp bz dn p f  pc fc
    // pass run
    vq.push_back(mk(1,0,0, 1,0,1,0,0,0, 0,0));
    vq.push_back(mk(0,0,0, 0,0,1,0,0,0, 0,0));
    vq.push_back(mk(0,1,0, 0,0,1,0,0,0, 0,0));
    vq.push_back(mk(0,1,0, 0,0,1,0,0,0, 0,0));
    vq.push_back(mk(0,1,0, 0,0,1,0,0,0, 0,0));
    vq.push_back(mk(0,0,1, 0,1,1,0,0,0, 0,0));
    vq.push_back(mk(0,0,1, 0,1,1,0,0,0, 0,0));
    vq.push_back(mk(0,0,0, 0,0,1,1,1,0, 1,0));
    vq.push_back(mk(0,0,0, 0,0,0,0,1,0, 1,0));
    // two good cycles then bad
    vq.push_back(mk(1,0,0, 1,0,1,0,1,0, 1,0));
    vq.push_back(mk(0,0,0, 0,0,1,0,1,0, 1,0));
    vq.push_back(mk(0,1,0, 0,0,1,0,1,0, 1,0));
    vq.push_back(mk(0,1,0, 0,0,1,0,1,0, 1,0));
    vq.push_back(mk(0,0,1, 0,0,1,1,0,1, 1,1));
    vq.push_back(mk(0,0,0, 0,0,0,0,0,1, 1,1));
    // good and bad together in RUN
    vq.push_back(mk(1,0,0, 1,0,1,0,0,1, 1,1));
    vq.push_back(mk(0,0,0, 0,0,1,0,0,1, 1,1));
    vq.push_back(mk(0,1,0, 0,0,1,0,0,1, 1,1));
    vq.push_back(mk(0,1,1, 0,0,1,1,0,1, 1,2));
    vq.push_back(mk(0,0,0, 0,0,0,0,0,1, 1,2));
    // four good cycles, go held mid-run
    vq.push_back(mk(1,0,0, 1,0,1,0,0,1, 1,2));
    vq.push_back(mk(1,0,0, 0,0,1,0,0,1, 1,2));
    vq.push_back(mk(1,1,0, 0,0,1,0,0,1, 1,2));
    vq.push_back(mk(1,1,0, 0,0,1,0,0,1, 1,2));
    vq.push_back(mk(1,1,0, 0,0,1,0,0,1, 1,2));
    vq.push_back(mk(1,1,0, 0,0,1,1,0,1, 1,3));
    vq.push_back(mk(0,0,0, 0,0,0,0,0,1, 1,3));
    // bad while waiting for good
    vq.push_back(mk(1,0,0, 1,0,1,0,0,1, 1,3));
    vq.push_back(mk(0,0,0, 0,0,1,0,0,1, 1,3));
    vq.push_back(mk(0,0,1, 0,0,1,1,0,1, 1,4));
    vq.push_back(mk(0,0,0, 0,0,0,0,0,1, 1,4));
    // good reappears during STOP
    vq.push_back(mk(1,0,0, 1,0,1,0,0,1, 1,4));
    vq.push_back(mk(0,0,0, 0,0,1,0,0,1, 1,4));
    vq.push_back(mk(0,1,0, 0,0,1,0,0,1, 1,4));
    vq.push_back(mk(0,1,0, 0,0,1,0,0,1, 1,4));
    vq.push_back(mk(0,1,0, 0,0,1,0,0,1, 1,4));
    vq.push_back(mk(0,0,1, 0,1,1,0,0,1, 1,4));
    vq.push_back(mk(0,1,0, 0,0,1,1,0,1, 1,5));
    vq.push_back(mk(0,0,0, 0,0,0,0,0,1, 1,5));
    // neither flag in RUN
    vq.push_back(mk(1,0,0, 1,0,1,0,0,1, 1,5));
    vq.push_back(mk(0,0,0, 0,0,1,0,0,1, 1,5));
    vq.push_back(mk(0,1,0, 0,0,1,0,0,1, 1,5));
    vq.push_back(mk(0,0,0, 0,0,1,1,0,1, 1,6));
    vq.push_back(mk(0,0,0, 0,0,0,0,0,1, 1,6));

    #12;
    chk("rst_a", {10'd0, outa}, 32'd0);
    chk("rst_b", {22'd0, b_start, b_stop, b_busy, b_done,
                  b_pass, b_fail, b_pc, b_fc}, 32'd0);
    rst_n = 1'b1; rst_b = 1'b1;
    step();
    chk("idle_a", {10'd0, outa}, 32'd0);

    foreach (vq[i]) apply(vq[i], i);

    // no answer from target: fail 16 cycles into WAIT_G
    go = 1'b1; step();
    go = 1'b0; step();
    n = 0;
    while (!a_done && n < 40) begin step(); n++; end
    chk("wait_tmo_cyc", n, 16);
    chk("wait_tmo_res", {a_pass, a_fail, a_fc}, {2'b01, 8'd7});
    step();

    // target stuck in END while stopped
    go = 1'b1; step();
    go = 1'b0; step();
    good = 1'b1; step(); step(); step();
    good = 1'b0; bad = 1'b1; step();
    chk("stop_on", a_stop, 1);
    n = 0;
    while (!a_done && n < 40) begin step(); n++; end
    chk("stop_tmo_cyc", n, 16);
    chk("stop_tmo_res", {a_stop, a_pass, a_fail, a_fc},
        {3'b001, 8'd8});
    bad = 1'b0; step();

    // async reset in RUN, then a clean pass run
    go = 1'b1; step();
    go = 1'b0; step();
    good = 1'b1; step();
    chk("pre_rst_busy", a_busy, 1);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst", {10'd0, outa}, 32'd0);
    good = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 9; i++) apply(vq[i], 100 + i);

    // demo target: start@T, stop@T+5..T+6, done&pass@T+7
    go_b = 1'b1; step();
    chk("b_start", b_start, 1);
    go_b = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      step();
      chk($sformatf("b_t%0d", t),
          {b_start, b_stop, b_busy, b_done, b_pass},
          {1'b0, (t == 5 || t == 6), (t <= 7),
           (t == 7), (t >= 7)});
    end
    chk("b_pcnt1", {b_pc, b_fc}, 4'b0100);

    // go held: five back-to-back runs, tally saturates
    #1 rst_b = 1'b0;
    #1 rst_b = 1'b1;
    go_b = 1'b1;
    k = 0; cyc = 0; last = 0;
    while (k < 5 && cyc < 200) begin
      step();
      cyc++;
      if (b_done) begin
        k++;
        chk($sformatf("b_sat%0d", k), b_pc,
            (k > 3) ? 3 : k);
        if (k > 1) chk($sformatf("b_gap%0d", k), cyc - last, 9);
        last = cyc;
        if (k == 5) go_b = 1'b0;
      end
    end
    chk("b_runs", k, 5);
    chk("b_fcnt", b_fc, 0);
    step();
    chk("b_idle1", b_busy, 0);
    step();
    chk("b_idle2", {b_busy, b_pass, b_pc}, 4'b0111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
